// File: rtl/mips_serial_divider.sv
// Iterative 32-bit signed/unsigned restoring divider; one quotient bit per cycle.
// Handshake: a start (OP_div|OP_divu) is accepted only while Stall=0; results are valid whenever Stall=0.
module mips_serial_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        OP_div,
  input  logic        OP_divu,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic [31:0] Quotient,
  output logic [31:0] Remainder,
  output logic        Stall,
  output logic        debug_state
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [5:0]  count, count_nxt;
  logic [31:0] rem_q, rem_nxt;
  logic [31:0] quo_q, quo_nxt;
  logic [31:0] div_mag, div_mag_nxt;
  logic        neg_q, neg_q_nxt;
  logic        neg_r, neg_r_nxt;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        sgn;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;

  assign sgn          = OP_div;
  assign dividend_abs = (sgn && Dividend[31]) ? (32'd0 - Dividend) : Dividend;
  assign divisor_abs  = (sgn && Divisor[31])  ? (32'd0 - Divisor)  : Divisor;

  // Partial remainder stays below the divisor magnitude, so 33 bits hold the trial's sign.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, div_mag};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      div_mag <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      rem_q   <= rem_nxt;
      quo_q   <= quo_nxt;
      div_mag <= div_mag_nxt;
      neg_q   <= neg_q_nxt;
      neg_r   <= neg_r_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    rem_nxt     = rem_q;
    quo_nxt     = quo_q;
    div_mag_nxt = div_mag;
    neg_q_nxt   = neg_q;
    neg_r_nxt   = neg_r;
    unique case (state)
      IDLE: begin
        if (OP_div || OP_divu) begin
          state_nxt   = BUSY;
          count_nxt   = 6'd32;
          rem_nxt     = 32'd0;
          quo_nxt     = dividend_abs;
          div_mag_nxt = divisor_abs;
          neg_q_nxt   = sgn & (Dividend[31] ^ Divisor[31]);
          neg_r_nxt   = sgn & Dividend[31];
        end
      end
      BUSY: begin
        if (!trial[32]) begin
          rem_nxt = trial[31:0];
          quo_nxt = {quo_q[30:0], 1'b1};
        end else begin
          rem_nxt = shifted[31:0];
          quo_nxt = {quo_q[30:0], 1'b0};
        end
        count_nxt = count - 6'd1;
        if (count == 6'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Stall       = (state == BUSY);
  assign debug_state = state;
  assign Quotient    = neg_q ? (32'd0 - quo_q) : quo_q;
  assign Remainder   = neg_r ? (32'd0 - rem_q) : rem_q;

endmodule

// File: doc/mips_serial_divider.md
# mips_serial_divider

- Iterative 32-bit signed/unsigned divider: the responder side of the ALU's divide-start/stall handshake.
- The ALU issues a one-cycle start pulse with operands. This block computes the quotient and remainder one bit per cycle.
- It holds `Stall` high while busy, then presents results that the ALU commits to HILO on the first cycle `Stall` is low.

## Interface
- Parameters: none; datapath width is fixed at 32.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `OP_div`  in  1  start a signed divide; sampled only in IDLE.
- `OP_divu`  in  1  start an unsigned divide; sampled only in IDLE.
- `Dividend`  in  32  numerator; sampled on the start edge only.
- `Divisor`  in  32  denominator; sampled on the start edge only.
- `Quotient`  out  32  result quotient; valid whenever `Stall`=0 after a completed operation.
- `Remainder`  out  32  result remainder; same validity as `Quotient`.
- `Stall`  out  1  high while a divide is in progress.

## Operation
- States:
  - IDLE: `Stall`=0.
  - BUSY: `Stall`=1; 6-bit iteration counter.
- IDLE -> BUSY on a rising edge with `OP_div`|`OP_divu` = 1. On that edge the block latches:
  - mode: signed if `OP_div`=1; `OP_div` has priority when both are high.
  - magnitude registers: |Dividend| and |Divisor| in signed mode, raw values in unsigned mode.
  - neg_q = Dividend[31] ^ Divisor[31], signed mode only.
  - neg_r = Dividend[31], signed mode only.
  - partial remainder cleared; counter = 32.
- BUSY, each edge performs one restoring step:
  - shift {partial remainder, quotient register} left 1, bringing in the next dividend MSB.
  - if the 33-bit trial (partial remainder − divisor magnitude) is non-negative: keep the difference and set quotient bit 0 to 1; otherwise restore and set it to 0.
  - decrement the counter.
- BUSY -> IDLE on the edge that completes the 32nd step (counter 1 -> 0).
- Outputs are combinational from the registers: `Quotient` = neg_q ? −q : q; `Remainder` = neg_r ? −r : r (two's complement, 32-bit wrap).
- Results hold unchanged in IDLE until the next start.
- Start requests in BUSY are ignored: no restart, no operand capture.
- Divide by zero follows the algorithm, no special case:
  - unsigned: `Quotient`=0xFFFFFFFF, `Remainder`=Dividend.
  - signed, dividend ≥ 0: `Quotient`=0xFFFFFFFF, `Remainder`=Dividend.
  - signed, dividend < 0: `Quotient`=0x00000001, `Remainder`=Dividend.
- Signed 0x80000000 / 0xFFFFFFFF: magnitude 0x80000000 is handled unsigned; `Quotient`=0x80000000, `Remainder`=0. No exception is signalled.
- Remainder sign always equals dividend sign (or is zero); |Remainder| < |Divisor| for a nonzero divisor.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, counter 0, all datapath registers 0.
- Reset output values: `Stall`=0, `Quotient`=0, `Remainder`=0.
- Start sampled at edge E0. `Stall`=1 from just after E0 through E32, i.e. exactly 32 cycles.
- `Stall`=0 and final results valid from just after E32. The ALU commits HILO at E33.
- Back-to-back: a new start in the first IDLE cycle (sampled at E33) is accepted. Results of the prior operation stay visible during that cycle.
- `reset` asserted mid-BUSY: immediate return to IDLE with `Stall`=0 and outputs 0; no partial result is exposed.
- No combinational path from `OP_div`/`OP_divu`/operands to `Stall`.

## Test plan
- Unsigned 100/7 (`OP_divu` pulse):
  - `Stall` high for exactly 32 cycles.
  - then `Quotient`=14 (0x0000000E), `Remainder`=2.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002): `Quotient`=0xFFFFFFFD, `Remainder`=0xFFFFFFFF.
- Signed 7/−2: `Quotient`=0xFFFFFFFD, `Remainder`=0x00000001.
- Overflow and unsigned counterpart:
  - signed 0x80000000 / 0xFFFFFFFF: `Quotient`=0x80000000, `Remainder`=0.
  - unsigned same operands: `Quotient`=0, `Remainder`=0x80000000.
- Divide by zero:
  - unsigned 0x12345678/0: `Quotient`=0xFFFFFFFF, `Remainder`=0x12345678.
  - signed 0xFFFFFFF0/0: `Quotient`=0x00000001, `Remainder`=0xFFFFFFF0.
- Protocol corner cases:
  - start 50/5, pulse `OP_div` with other operands at cycle 10 of BUSY: ignored, still 32-cycle stall, result 10 r 0.
  - assert `reset` at cycle 20 of BUSY: `Stall`=0 and outputs 0 immediately.
  - after reset release, unsigned 9/4 gives 2 r 1 after 32 cycles.
